// File: rtl/video_ram_fill.sv
// video_ram_fill: block RAM with handshake write port, 1/2-cycle scan-out read port and fill engine
module video_ram_fill #(
  parameter int DATA_W = 9,
  parameter int DEPTH = 2048,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int READ_LATENCY = 2,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_ad,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_ad,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_value,
  output logic              fill_busy
);
  typedef enum logic {IDLE, FILL} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] fill_ad, wa;
  logic [DATA_W-1:0] fill_val, wd, ram_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic we, ram_v;
  assign fill_busy = state == FILL;
  assign wr_ready = !fill_busy;
  assign we = fill_busy ? !reset : wr_valid;
  assign wa = fill_busy ? fill_ad : wr_ad;
  assign wd = fill_busy ? fill_val : wr_data;
  always_comb begin
    state_n = state;
    if (fill_busy)
      state_n = fill_ad == ADDR_W'(DEPTH - 1) ? IDLE : FILL;
    else
      state_n = fill_start ? FILL : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      fill_ad <= '0;
    end else begin
      state <= state_n;
      fill_ad <= fill_busy && state_n == FILL ? fill_ad + 1'b1 : '0;
      if (!fill_busy && fill_start) fill_val <= fill_value;
    end
  end
  always_ff @(posedge clk) begin
    if (we && int'(wa) < DEPTH) mem[wa] <= wd;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_v <= 1'b0;
      ram_q <= '0;
    end else begin
      ram_v <= rd_en;
      if (rd_en) ram_q <= int'(rd_ad) < DEPTH ? mem[rd_ad] : '0;
    end
  end
  if (READ_LATENCY == 1) begin : g_lat1
    assign rd_data = ram_q;
    assign rd_valid = ram_v;
  end else begin : g_lat2
    always_ff @(posedge clk) begin
      if (reset) begin
        rd_valid <= 1'b0;
        rd_data <= '0;
      end else begin
        rd_valid <= ram_v;
        if (ram_v) rd_data <= ram_q;
      end
    end
  end
endmodule

// File: tb/tb_video_ram_fill.sv
// tb_video_ram_fill: directed checks of latency, handshake, fill, reset abort and out-of-range access
module tb_video_ram_fill;
  logic clk = 0, reset = 1, wr_valid = 0, rd_en = 0, fill_start = 0;
  logic [10:0] wr_ad = 0, rd_ad = 0;
  logic [8:0] wr_data = 0, fill_value = 0;
  logic [9:0] wr_ad3, rd_ad3;
  logic [8:0] rd_data1, rd_data2, rd_data3;
  logic rd_valid1, rd_valid2, rd_valid3, wr_ready1, wr_ready2, wr_ready3;
  logic fill_busy1, fill_busy2, fill_busy3;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    logic [10:0] ad;
    logic [8:0] d;
  } vec_t;
  vec_t tab[5];
  assign wr_ad3 = wr_ad[9:0];
  assign rd_ad3 = rd_ad[9:0];
  always #5 clk = ~clk;
  video_ram_fill #(.DATA_W(9), .DEPTH(2048), .READ_LATENCY(2)) u2 (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready2), .wr_ad(wr_ad),
    .wr_data(wr_data), .rd_en(rd_en), .rd_ad(rd_ad), .rd_data(rd_data2), .rd_valid(rd_valid2),
    .fill_start(fill_start), .fill_value(fill_value), .fill_busy(fill_busy2));
  video_ram_fill #(.DATA_W(9), .DEPTH(2048), .READ_LATENCY(1)) u1 (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready1), .wr_ad(wr_ad),
    .wr_data(wr_data), .rd_en(rd_en), .rd_ad(rd_ad), .rd_data(rd_data1), .rd_valid(rd_valid1),
    .fill_start(1'b0), .fill_value(9'd0), .fill_busy(fill_busy1));
  video_ram_fill #(.DATA_W(9), .DEPTH(1000), .READ_LATENCY(2)) u3 (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready3), .wr_ad(wr_ad3),
    .wr_data(wr_data), .rd_en(rd_en), .rd_ad(rd_ad3), .rd_data(rd_data3), .rd_valid(rd_valid3),
    .fill_start(1'b0), .fill_value(9'd0), .fill_busy(fill_busy3));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic wr(input logic [10:0] a, input logic [8:0] d);
    wr_valid = 1;
    wr_ad = a;
    wr_data = d;
    tick;
    wr_valid = 0;
  endtask
  task automatic rd2(input logic [10:0] a, input logic [8:0] e, input string name);
    rd_en = 1;
    rd_ad = a;
    tick;
    rd_en = 0;
    tick;
    chk({name, " valid"}, 32'(rd_valid2), 1);
    chk(name, 32'(rd_data2), 32'(e));
  endtask
  task automatic rd3(input logic [10:0] a, input logic [8:0] e, input string name);
    rd_en = 1;
    rd_ad = a;
    tick;
    rd_en = 0;
    chk({name, " early valid"}, 32'(rd_valid3), 0);
    tick;
    chk({name, " valid"}, 32'(rd_valid3), 1);
    chk(name, 32'(rd_data3), 32'(e));
  endtask
  task automatic start_fill(input logic [8:0] v);
    fill_start = 1;
    fill_value = v;
    tick;
    fill_start = 0;
  endtask
  task automatic run_fill(input int stop_at, input logic [8:0] v2, output int cnt, output logic bad);
    cnt = 0;
    bad = 0;
    while (fill_busy2 && cnt < 5000) begin
      if (wr_ready2) bad = 1;
      cnt++;
      fill_start = cnt == stop_at;
      if (cnt == stop_at) fill_value = v2;
      tick;
    end
    fill_start = 0;
  endtask
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end
  initial begin
    int cnt;
    logic bad;
    tab[0] = '{11'h7FF, 9'h1A5};
    tab[1] = '{11'h010, 9'h003};
    tab[2] = '{11'h011, 9'h004};
    tab[3] = '{11'h000, 9'h111};
    tab[4] = '{11'h123, 9'h0C3};
    tick;
    tick;
    chk("reset rd_valid2", 32'(rd_valid2), 0);
    chk("reset rd_data2", 32'(rd_data2), 0);
    chk("reset rd_valid1", 32'(rd_valid1), 0);
    chk("reset rd_data1", 32'(rd_data1), 0);
    chk("reset fill_busy", 32'(fill_busy2), 0);
    chk("reset fill_busy1", 32'(fill_busy1), 0);
    chk("reset fill_busy3", 32'(fill_busy3), 0);
    chk("reset wr_ready", 32'(wr_ready2), 1);
    chk("reset wr_ready1", 32'(wr_ready1), 1);
    reset = 0;
    tick;
    foreach (tab[i]) wr(tab[i].ad, tab[i].d);
    rd_en = 1;
    rd_ad = 11'h7FF;
    tick;
    rd_en = 0;
    chk("lat2 N+1 valid", 32'(rd_valid2), 0);
    chk("lat1 N+1 valid", 32'(rd_valid1), 1);
    chk("lat1 N+1 data", 32'(rd_data1), 32'h1A5);
    tick;
    chk("lat2 N+2 valid", 32'(rd_valid2), 1);
    chk("lat2 N+2 data", 32'(rd_data2), 32'h1A5);
    chk("lat1 N+2 valid", 32'(rd_valid1), 0);
    chk("lat1 hold data", 32'(rd_data1), 32'h1A5);
    for (int i = 0; i <= 5; i++) begin
      rd_en = i < 5;
      rd_ad = i < 5 ? tab[i].ad : 11'h0;
      tick;
      if (i < 5) begin
        chk($sformatf("b2b lat1 valid %0d", i), 32'(rd_valid1), 1);
        chk($sformatf("b2b lat1 data %0d", i), 32'(rd_data1), 32'(tab[i].d));
      end else
        chk("b2b lat1 end valid", 32'(rd_valid1), 0);
      if (i > 0) begin
        chk($sformatf("b2b lat2 valid %0d", i - 1), 32'(rd_valid2), 1);
        chk($sformatf("b2b lat2 data %0d", i - 1), 32'(rd_data2), 32'(tab[i-1].d));
      end
    end
    rd_en = 0;
    wr_valid = 1;
    wr_ad = 11'h010;
    wr_data = 9'h055;
    rd_en = 1;
    rd_ad = 11'h010;
    tick;
    wr_valid = 0;
    rd_en = 0;
    chk("rdw lat1 old data", 32'(rd_data1), 32'h003);
    tick;
    chk("rdw lat2 old data", 32'(rd_data2), 32'h003);
    rd2(11'h010, 9'h055, "rdw new data");
    wr(11'h000, 9'h033);
    wr(11'd999, 9'h099);
    wr_valid = 1;
    wr_ad = 11'd1000;
    wr_data = 9'h0AB;
    chk("oor write ready", 32'(wr_ready3), 1);
    tick;
    wr_valid = 0;
    rd3(11'd1000, 9'h000, "oor read 1000");
    rd3(11'd0, 9'h033, "d1000 addr 0");
    rd3(11'd999, 9'h099, "d1000 addr 999");
    rd3(11'd1023, 9'h000, "oor read 1023");
    start_fill(9'h020);
    chk("fill busy rises", 32'(fill_busy2), 1);
    wr_valid = 1;
    wr_ad = 11'h005;
    wr_data = 9'h0FF;
    run_fill(0, 9'h000, cnt, bad);
    chk("fill length", 32'(cnt), 2048);
    chk("wr_ready low in fill", 32'(bad), 0);
    chk("wr_ready after fill", 32'(wr_ready2), 1);
    tick;
    wr_valid = 0;
    rd2(11'h000, 9'h020, "fill addr 0");
    rd2(11'h004, 9'h020, "fill addr 4");
    rd2(11'h005, 9'h0FF, "held write 5");
    rd2(11'h006, 9'h020, "fill addr 6");
    rd2(11'h7FF, 9'h020, "fill addr 7ff");
    wr_valid = 1;
    wr_ad = 11'h000;
    wr_data = 9'h111;
    fill_start = 1;
    fill_value = 9'h000;
    tick;
    wr_valid = 0;
    fill_start = 0;
    chk("fill2 busy rises", 32'(fill_busy2), 1);
    run_fill(1000, 9'h1FF, cnt, bad);
    chk("fill2 length with restart", 32'(cnt), 2048);
    rd2(11'h000, 9'h000, "fill2 overwrites write");
    rd2(11'h7FF, 9'h000, "fill2 value kept");
    start_fill(9'h0AA);
    run_fill(0, 9'h000, cnt, bad);
    start_fill(9'h1FF);
    for (int i = 0; i < 100; i++) tick;
    chk("abort busy before reset", 32'(fill_busy2), 1);
    reset = 1;
    tick;
    chk("abort busy", 32'(fill_busy2), 0);
    chk("abort wr_ready", 32'(wr_ready2), 1);
    reset = 0;
    rd2(11'd0, 9'h1FF, "abort addr 0");
    rd2(11'd99, 9'h1FF, "abort addr 99");
    rd2(11'd100, 9'h0AA, "abort addr 100");
    rd2(11'h7FF, 9'h0AA, "abort addr 7ff");
    rd_en = 1;
    rd_ad = 11'd0;
    tick;
    rd_en = 0;
    reset = 1;
    tick;
    chk("flush valid in reset", 32'(rd_valid2), 0);
    reset = 0;
    tick;
    chk("flush valid after reset", 32'(rd_valid2), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
